float_sweep_gen: RTL and testbench

- Stimulus-side counterpart to the float waveform evaluators (sawtooth_wave and its siblings), which consume an IEEE-754 single-precision x sample per clock.
- Produces a programmable linear sweep of x values: a signed fixed-point accumulator is stepped once per accepted sample and converted to IEEE-754 single.
- Delivers samples over a valid/ready stream, so a sweep runs in hardware rather than from bench real arithmetic.

---
 rtl/float_pkg.sv | 21 ++
 rtl/fix2float.sv | 30 +++
 rtl/float_sweep_gen.sv | 97 +++++++++
 tb/tb_float_sweep_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field definitions and sweep FSM states
// for the float stimulus blocks.
package float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [MAN_W-1:0] man;
  } float_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sweep_state_e;

endpackage

// File: rtl/fix2float.sv
// Signed 32-bit fixed point (FRAC_BITS fraction bits) to IEEE-754 single.
// Purely combinational; truncates extra mantissa bits (round toward zero).
module fix2float #(
  parameter int FRAC_BITS = 16
) (
  input  logic [31:0] i_fix,
  output logic [31:0] o_float
);
  import float_pkg::*;

  logic [31:0] w_mag;
  logic [4:0]  w_pos;
  logic [31:0] w_norm;
  float_t      w_f;

  // Magnitude of 0x8000_0000 is 2^31, which still fits as unsigned.
  always_comb begin
    w_mag = i_fix[31] ? (~i_fix + 32'd1) : i_fix;
    w_pos = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_pos = 5'(i);
    end
    w_norm   = w_mag << (5'd31 - w_pos);
    w_f.sign = i_fix[31];
    w_f.expo = EXP_W'(EXP_BIAS + int'(w_pos) - FRAC_BITS);
    w_f.man  = MAN_W'(w_norm >> (31 - MAN_W));
    o_float  = (i_fix == 32'd0) ? 32'd0 : w_f;
  end

endmodule

// File: rtl/float_sweep_gen.sv
// Linear sweep generator: fixed-point accumulator stepped per accepted sample,
// converted to IEEE-754 single and delivered over a valid/ready stream.
module float_sweep_gen #(
  parameter int          FRAC_BITS = 16,
  parameter logic [31:0] START     = 32'hFFFB_0000,
  parameter logic [31:0] STEP      = 32'h0000_028F,
  parameter int          COUNT     = 1000,
  parameter int          IDX_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_x_out,
  output logic [IDX_W-1:0] o_idx
);
  import float_pkg::*;

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(COUNT - 1);

  sweep_state_e     r_state, w_next;
  logic [31:0]      r_acc, r_x;
  logic [IDX_W:0]   r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid, r_done, r_ovf;
  logic [31:0]      w_sum, w_float;
  logic             w_load, w_xfer, w_accept, w_wrap;

  assign w_xfer   = r_valid && i_out_ready;
  assign w_load   = (r_state == RUN) && (!r_valid || i_out_ready);
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_sum    = r_acc + STEP;
  assign w_wrap   = (r_acc[31] == STEP[31]) && (w_sum[31] != r_acc[31]);

  fix2float #(.FRAC_BITS(FRAC_BITS)) u_fix2float (
    .i_fix   (r_acc),
    .o_float (w_float)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_load && (r_cnt == LAST)) w_next = DRAIN;
      DRAIN:   if (w_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The last load in RUN leaves out_valid high; DRAIN only waits for its transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= START;
      r_cnt   <= '0;
      r_x     <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc <= START;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
      if (w_load) begin
        r_x     <= w_float;
        r_idx   <= r_cnt[IDX_W-1:0];
        r_valid <= 1'b1;
        r_acc   <= w_sum;
        r_cnt   <= r_cnt + 1'b1;
        if (w_wrap) r_ovf <= 1'b1;
      end else if ((r_state == DRAIN) && w_xfer) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_ovf       = r_ovf;
  assign o_out_valid = r_valid;
  assign o_x_out     = r_x;
  assign o_idx       = r_idx;

endmodule

// File: tb/tb_float_sweep_gen.sv
// Directed bench for float_sweep_gen: five instances with different sweep
// parameters share one clock and reset; expected floats are hand-computed.
module tb_float_sweep_gen;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] start, ready, busy, done, ovf, valid;
  logic [31:0] xOut [5];
  logic [9:0]  idx  [5];

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  // Instance 0: default parameters (-5.0 upward, 1000 samples).
  float_sweep_gen dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_ovf(ovf[0]), .o_out_valid(valid[0]),
    .i_out_ready(ready[0]), .o_x_out(xOut[0]), .o_idx(idx[0]));

  float_sweep_gen #(.START(32'h0000_0000), .COUNT(3)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_ovf(ovf[1]), .o_out_valid(valid[1]),
    .i_out_ready(ready[1]), .o_x_out(xOut[1]), .o_idx(idx[1]));

  float_sweep_gen #(.START(32'h0001_0000), .COUNT(1)) dutC (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start[2]), .o_busy(busy[2]),
    .o_done(done[2]), .o_ovf(ovf[2]), .o_out_valid(valid[2]),
    .i_out_ready(ready[2]), .o_x_out(xOut[2]), .o_idx(idx[2]));

  float_sweep_gen #(.START(32'h8000_0000), .COUNT(3)) dutD (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start[3]), .o_busy(busy[3]),
    .o_done(done[3]), .o_ovf(ovf[3]), .o_out_valid(valid[3]),
    .i_out_ready(ready[3]), .o_x_out(xOut[3]), .o_idx(idx[3]));

  float_sweep_gen #(.START(32'h7FFF_0000), .STEP(32'h0001_0000), .COUNT(4)) dutE (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start[4]), .o_busy(busy[4]),
    .o_done(done[4]), .o_ovf(ovf[4]), .o_out_valid(valid[4]),
    .i_out_ready(ready[4]), .o_x_out(xOut[4]), .o_idx(idx[4]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, expv, $time);
    else
      passCount++;
  endtask

  // One-cycle start pulse; returns at the negedge after the accepting posedge.
  task automatic applyStimulus(input int k);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Consume samples with ready high until done, optionally stalling 3 cycles
  // when idx == stallAt; firstIdx is the index currently presented.
  task automatic runSweep(input int k, input int expN, input int stallAt, input int firstIdx);
    int  expIdx  = firstIdx;
    int  cycles  = 0;
    bit  seqOk   = 1'b1;
    bit  stalled = 1'b0;
    logic [31:0] heldX;
    ready[k] = 1'b1;
    while (!done[k] && cycles < expN * 2 + 20) begin
      if (valid[k] && !stalled && int'(idx[k]) == stallAt) begin
        heldX    = xOut[k];
        ready[k] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("holdX", xOut[k], heldX);
          checkOutput("holdIdx", {22'd0, idx[k]}, stallAt);
          checkOutput("holdValid", {31'd0, valid[k]}, 32'd1);
        end
        ready[k] = 1'b1;
        stalled  = 1'b1;
      end
      if (valid[k] && ready[k]) begin
        if (int'(idx[k]) != expIdx) seqOk = 1'b0;
        expIdx++;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("doneSeen", {31'd0, done[k]}, 32'd1);
    checkOutput("xferCount", expIdx, expN);
    checkOutput("idxSeq", {31'd0, seqOk}, 32'd1);
    checkOutput("busyAfter", {31'd0, busy[k]}, 32'd0);
    checkOutput("validAfter", {31'd0, valid[k]}, 32'd0);
    @(negedge clk);
    checkOutput("donePulse", {31'd0, done[k]}, 32'd0);
  endtask

  initial begin
    rstN  = 1'b0;
    start = '0;
    ready = '1;
    @(negedge clk);
    checkOutput("rstValid", {31'd0, valid[0]}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy[0]}, 32'd0);
    checkOutput("rstDone", {31'd0, done[0]}, 32'd0);
    checkOutput("rstOvf", {31'd0, ovf[0]}, 32'd0);
    checkOutput("rstX", xOut[0], 32'd0);
    checkOutput("rstIdx", {22'd0, idx[0]}, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // Default sweep with a 3-cycle stall at sample 5.
    applyStimulus(0);
    checkOutput("A.validLatency", {31'd0, valid[0]}, 32'd0);
    checkOutput("A.busy", {31'd0, busy[0]}, 32'd1);
    @(negedge clk);
    checkOutput("A.valid0", {31'd0, valid[0]}, 32'd1);
    checkOutput("A.x0", xOut[0], 32'hC0A0_0000);
    checkOutput("A.idx0", {22'd0, idx[0]}, 32'd0);
    @(negedge clk);
    checkOutput("A.x1", xOut[0], 32'hC09F_AE20);
    checkOutput("A.idx1", {22'd0, idx[0]}, 32'd1);
    runSweep(0, 1000, 5, 1);
    checkOutput("A.ovf", {31'd0, ovf[0]}, 32'd0);

    applyStimulus(1);
    @(negedge clk);
    checkOutput("B.x0", xOut[1], 32'h0000_0000);
    checkOutput("B.valid0", {31'd0, valid[1]}, 32'd1);
    @(negedge clk);
    checkOutput("B.x1", xOut[1], 32'h3C23_C000);
    checkOutput("B.idx1", {22'd0, idx[1]}, 32'd1);
    runSweep(1, 3, -1, 1);

    applyStimulus(2);
    @(negedge clk);
    checkOutput("C.x0", xOut[2], 32'h3F80_0000);
    runSweep(2, 1, -1, 0);

    // Extra start while RUN must be ignored; a start in IDLE restarts.
    applyStimulus(3);
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    checkOutput("D.x0", xOut[3], 32'hC700_0000);
    runSweep(3, 3, -1, 0);
    applyStimulus(3);
    @(negedge clk);
    checkOutput("D.restartX", xOut[3], 32'hC700_0000);
    checkOutput("D.restartIdx", {22'd0, idx[3]}, 32'd0);
    runSweep(3, 3, -1, 0);

    // Accumulator wraps 32767.0 -> -32768.0; then reset mid-sweep.
    applyStimulus(4);
    checkOutput("E.ovfCleared", {31'd0, ovf[4]}, 32'd0);
    @(negedge clk);
    checkOutput("E.x0", xOut[4], 32'h46FF_FE00);
    @(negedge clk);
    checkOutput("E.x1", xOut[4], 32'hC700_0000);
    checkOutput("E.ovfSet", {31'd0, ovf[4]}, 32'd1);
    checkOutput("E.busyMid", {31'd0, busy[4]}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("E.rstValid", {31'd0, valid[4]}, 32'd0);
    checkOutput("E.rstBusy", {31'd0, busy[4]}, 32'd0);
    checkOutput("E.rstOvf", {31'd0, ovf[4]}, 32'd0);
    checkOutput("E.rstX", xOut[4], 32'd0);
    checkOutput("E.rstIdx", {22'd0, idx[4]}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("E.rstNoDone", {31'd0, done[4]}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("E.idleAfterRst", {31'd0, busy[4]}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
